mips_soc_top: RTL and testbench

Top-level single-clock SoC: a single-cycle 32-bit MIPS-subset core fetching from and storing to one unified word memory. Its only external output is a 16-bit LED register, written by a memory-mapped store. The block is the chip top for the LED demo board. Programs are preloaded into the memory array by the bench or by the boot image; the core runs them from address 0 after reset.

---
 rtl/mips_pkg.sv | 107 ++++++++++
 rtl/mips_mem_if.sv | 16 +
 rtl/mips_core.sv | 103 ++++++++++
 rtl/mips_mem.sv | 20 ++
 rtl/mips_mem_array.sv | 24 ++
 rtl/mips_regfile.sv | 29 ++
 rtl/mips_soc_top.sv | 32 +++
 tb/tb_mips_soc_top.sv | 315 +++++++++++++++++++++++++++++++
 8 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-subset SoC: sizes, opcode/funct encodings,
// ALU operations and the decoded control bundle.
package mips_pkg;

   localparam int unsigned XLEN          = 32;
   localparam int unsigned REG_AW        = 5;
   localparam int unsigned NUM_REGS      = 32;
   localparam int unsigned MEM_DEPTH     = 512;
   localparam int unsigned MEM_AW        = 9;
   localparam int unsigned LED_WORD_ADDR = 321;
   localparam int unsigned LED_W         = 16;

   localparam logic [MEM_AW-1:0] LED_IDX = MEM_AW'(LED_WORD_ADDR);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
   } alu_op_e;

   typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} reg_dst_e;

   typedef struct packed {
      logic     reg_write;
      reg_dst_e reg_dst;
      logic     alu_imm;
      logic     zero_ext;
      logic     mem_write;
      logic     mem_to_reg;
      logic     beq;
      logic     bne;
      logic     jump;
      logic     link;
      logic     jr;
      alu_op_e  alu_op;
   } ctrl_t;

   // Unknown opcode/funct falls through with all controls low, i.e. a nop.
   function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: begin
            c.reg_dst = DST_RD;
            c.reg_write = 1'b1;
            case (funct)
               FN_ADD, FN_ADDU: c.alu_op = ALU_ADD;
               FN_SUB, FN_SUBU: c.alu_op = ALU_SUB;
               FN_AND:          c.alu_op = ALU_AND;
               FN_OR:           c.alu_op = ALU_OR;
               FN_XOR:          c.alu_op = ALU_XOR;
               FN_NOR:          c.alu_op = ALU_NOR;
               FN_SLT:          c.alu_op = ALU_SLT;
               FN_SLL:          c.alu_op = ALU_SLL;
               FN_SRL:          c.alu_op = ALU_SRL;
               FN_JR: begin
                  c.reg_write = 1'b0;
                  c.jr        = 1'b1;
               end
               default:         c.reg_write = 1'b0;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin c.reg_write = 1'b1; c.alu_imm = 1'b1; c.alu_op = ALU_ADD; end
         OP_SLTI: begin c.reg_write = 1'b1; c.alu_imm = 1'b1; c.alu_op = ALU_SLT; end
         OP_ANDI: begin c.reg_write = 1'b1; c.alu_imm = 1'b1; c.zero_ext = 1'b1; c.alu_op = ALU_AND; end
         OP_ORI:  begin c.reg_write = 1'b1; c.alu_imm = 1'b1; c.zero_ext = 1'b1; c.alu_op = ALU_OR; end
         OP_XORI: begin c.reg_write = 1'b1; c.alu_imm = 1'b1; c.zero_ext = 1'b1; c.alu_op = ALU_XOR; end
         OP_LUI:  begin c.reg_write = 1'b1; c.alu_op = ALU_LUI; end
         OP_LW:   begin c.reg_write = 1'b1; c.alu_imm = 1'b1; c.mem_to_reg = 1'b1; end
         OP_SW:   begin c.mem_write = 1'b1; c.alu_imm = 1'b1; end
         OP_BEQ:  c.beq = 1'b1;
         OP_BNE:  c.bne = 1'b1;
         OP_J:    c.jump = 1'b1;
         OP_JAL:  begin c.jump = 1'b1; c.link = 1'b1; c.reg_write = 1'b1; c.reg_dst = DST_RA; end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mips_mem_if.sv
// Core-to-memory bus: asynchronous instruction and data read ports, one write port.
interface mips_mem_if;
   import mips_pkg::*;

   logic [MEM_AW-1:0] imem_addr;
   logic [XLEN-1:0]   imem_rdata;
   logic [MEM_AW-1:0] dmem_addr;
   logic [XLEN-1:0]   dmem_wdata;
   logic              dmem_we;
   logic [XLEN-1:0]   dmem_rdata;

   modport master (output imem_addr, dmem_addr, dmem_wdata, dmem_we,
                   input  imem_rdata, dmem_rdata);
   modport slave  (input  imem_addr, dmem_addr, dmem_wdata, dmem_we,
                   output imem_rdata, dmem_rdata);
endinterface

// File: rtl/mips_core.sv
// Single-cycle MIPS-subset core: PC, decode, register file, ALU and next-PC selection.
module mips_core
   import mips_pkg::*;
(
   input logic        clk,
   input logic        rst_n,
   mips_mem_if.master bus
);

   logic [XLEN-1:0]   pc, pc_plus4, pc_next, branch_tgt, jump_tgt;
   logic [XLEN-1:0]   instr, imm_ext, rs_val, rt_val, alu_b, alu_res, wr_data;
   logic [5:0]        op, funct;
   logic [REG_AW-1:0] rs, rt, rd, wr_addr;
   logic [4:0]        shamt;
   logic [15:0]       imm;
   logic [25:0]       idx;
   logic              rf_we;
   ctrl_t             ctrl;
   logic              unused_addr_bits;

   assign bus.imem_addr = pc[MEM_AW+1:2];
   assign instr = bus.imem_rdata;

   assign op    = instr[31:26];
   assign rs    = instr[25:21];
   assign rt    = instr[20:16];
   assign rd    = instr[15:11];
   assign shamt = instr[10:6];
   assign funct = instr[5:0];
   assign imm   = instr[15:0];
   assign idx   = instr[25:0];

   assign ctrl    = decode(op, funct);
   assign imm_ext = ctrl.zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};

   mips_regfile u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .raddr_a (rs),
      .rdata_a (rs_val),
      .raddr_b (rt),
      .rdata_b (rt_val),
      .we      (rf_we),
      .waddr   (wr_addr),
      .wdata   (wr_data)
   );

   assign alu_b = ctrl.alu_imm ? imm_ext : rt_val;

   always_comb begin
      alu_res = '0;
      case (ctrl.alu_op)
         ALU_ADD: alu_res = rs_val + alu_b;
         ALU_SUB: alu_res = rs_val - alu_b;
         ALU_AND: alu_res = rs_val & alu_b;
         ALU_OR:  alu_res = rs_val | alu_b;
         ALU_XOR: alu_res = rs_val ^ alu_b;
         ALU_NOR: alu_res = ~(rs_val | alu_b);
         ALU_SLT: alu_res = {31'b0, $signed(rs_val) < $signed(alu_b)};
         ALU_SLL: alu_res = rt_val << shamt;
         ALU_SRL: alu_res = rt_val >> shamt;
         ALU_LUI: alu_res = {imm, 16'h0000};
         default: alu_res = '0;
      endcase
   end

   // Writes are suppressed while reset is held so an aborted instruction commits nothing.
   assign bus.dmem_addr  = alu_res[MEM_AW+1:2];
   assign bus.dmem_wdata = rt_val;
   assign bus.dmem_we    = ctrl.mem_write & rst_n;
   assign rf_we          = ctrl.reg_write & rst_n;
   assign unused_addr_bits = ^{alu_res[XLEN-1:MEM_AW+2], alu_res[1:0]};

   always_comb begin
      wr_addr = rt;
      case (ctrl.reg_dst)
         DST_RD:  wr_addr = rd;
         DST_RA:  wr_addr = REG_AW'(31);
         default: wr_addr = rt;
      endcase
   end

   assign wr_data = ctrl.link       ? pc_plus4 :
                    ctrl.mem_to_reg ? bus.dmem_rdata : alu_res;

   assign pc_plus4   = pc + 32'd4;
   assign branch_tgt = pc_plus4 + {imm_ext[29:0], 2'b00};
   assign jump_tgt   = {pc_plus4[31:28], idx, 2'b00};

   always_comb begin
      pc_next = pc_plus4;
      if (ctrl.jr)                              pc_next = rs_val;
      else if (ctrl.jump)                       pc_next = jump_tgt;
      else if (ctrl.beq && (rs_val == rt_val))  pc_next = branch_tgt;
      else if (ctrl.bne && (rs_val != rt_val))  pc_next = branch_tgt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= '0;
      else        pc <= pc_next;
   end

endmodule

// File: rtl/mips_mem.sv
// Memory wrapper: maps the core bus onto the shared array (fetch on port A, data on port B).
module mips_mem
   import mips_pkg::*;
(
   input logic       clk,
   mips_mem_if.slave bus
);

   mips_mem_array u_mem (
      .clk     (clk),
      .we      (bus.dmem_we),
      .waddr   (bus.dmem_addr),
      .wdata   (bus.dmem_wdata),
      .raddr_a (bus.imem_addr),
      .rdata_a (bus.imem_rdata),
      .raddr_b (bus.dmem_addr),
      .rdata_b (bus.dmem_rdata)
   );

endmodule

// File: rtl/mips_mem_array.sv
// Unified word memory: two asynchronous read ports, one synchronous write port, never reset.
module mips_mem_array
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [MEM_AW-1:0] waddr,
   input  logic [XLEN-1:0]   wdata,
   input  logic [MEM_AW-1:0] raddr_a,
   output logic [XLEN-1:0]   rdata_a,
   input  logic [MEM_AW-1:0] raddr_b,
   output logic [XLEN-1:0]   rdata_b
);

   logic [XLEN-1:0] mem [0:MEM_DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one rising-edge write port, $0 hardwired to zero.
module mips_regfile
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] raddr_a,
   output logic [XLEN-1:0]   rdata_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [XLEN-1:0]   rdata_b,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [XLEN-1:0]   wdata
);

   logic [XLEN-1:0] regs [0:NUM_REGS-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
   assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mips_soc_top.sv
// LED demo chip top: MIPS-subset core, unified memory and a memory-mapped 16-bit LED register.
module mips_soc_top
   import mips_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_arst_n,
   output logic [LED_W-1:0] o_leds
);

   mips_mem_if bus ();

   mips_core u_core (
      .clk   (i_clk),
      .rst_n (i_arst_n),
      .bus   (bus.master)
   );

   mips_mem mem (
      .clk (i_clk),
      .bus (bus.slave)
   );

   // Stores to the LED word update memory and the LED register on the same edge.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         o_leds <= '0;
      end else if (bus.dmem_we && (bus.dmem_addr == LED_IDX)) begin
         o_leds <= bus.dmem_wdata[LED_W-1:0];
      end
   end

endmodule

// File: tb/tb_mips_soc_top.sv
// Directed bench for mips_soc_top: hand-assembled programs preloaded under reset, results read from memory and LEDs.
module tb_mips_soc_top;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic [15:0] leds;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   mips_soc_top dut (
      .i_clk    (clk),
      .i_arst_n (arst_n),
      .o_leds   (leds)
   );

   always #10 clk = ~clk;

   function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] j_op(input logic [5:0] op, input logic [25:0] idx);
      return {op, idx};
   endfunction

   task automatic poke(input int idx, input logic [31:0] v);
      dut.mem.u_mem.mem[idx] = v;
   endtask

   function automatic logic [31:0] peek(input int idx);
      return dut.mem.u_mem.mem[idx];
   endfunction

   // Enter reset and wipe memory; program words are poked afterwards.
   task automatic enter_reset_clear();
      @(negedge clk);
      arst_n = 1'b0;
      for (int i = 0; i < 512; i++) poke(i, 32'h0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      arst_n = 1'b1;
   endtask

   // Standard ending: store 1 to word 320, then spin.
   task automatic poke_epilogue(input int at);
      poke(at,     i_op(6'h08, 5'd0, 5'd3, 16'h0001));
      poke(at + 1, i_op(6'h2B, 5'd0, 5'd3, 16'h0500));
      poke(at + 2, j_op(6'h02, 26'(at + 2)));
   endtask

   task automatic wait_done(output logic ok);
      ok = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (peek(320) == 32'h1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic load_led_program();
      poke(0, i_op(6'h08, 5'd0, 5'd1, 16'h0018));
      poke(1, r_op(5'd1, 5'd1, 5'd2, 5'd0, 6'h20));
      poke(2, i_op(6'h2B, 5'd0, 5'd2, 16'h0504));
      poke_epilogue(3);
   endtask

   task automatic test_reset();
      logic leds_bad;
      int   nonzero;
      enter_reset_clear();
      #1;
      vectors++;
      if (dut.u_core.pc !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_pc: got %h want %h", dut.u_core.pc, 32'h0);
      end
      vectors++;
      if (leds !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_leds: got %h want %h", leds, 16'h0);
      end
      release_reset();
      leds_bad = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (leds !== 16'h0) leds_bad = 1'b1;
      end
      @(negedge clk);
      vectors++;
      if (dut.u_core.pc !== 32'd40) begin
         miscompares++;
         $display("FAIL nop_pc_step: got %0d want %0d", dut.u_core.pc, 40);
      end
      vectors++;
      if (leds_bad !== 1'b0) begin
         miscompares++;
         $display("FAIL nop_leds_quiet: got %b want %b", leds_bad, 1'b0);
      end
      nonzero = 0;
      for (int i = 0; i < 512; i++) if (peek(i) !== 32'h0) nonzero++;
      vectors++;
      if (nonzero != 0) begin
         miscompares++;
         $display("FAIL nop_mem_untouched: got %0d changed words want %0d", nonzero, 0);
      end
   endtask

   task automatic test_led_program();
      logic ok;
      enter_reset_clear();
      load_led_program();
      release_reset();
      wait_done(ok);
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++;
         $display("FAIL led_prog_done: got %b want %b", ok, 1'b1);
      end
      vectors++;
      if (leds !== 16'h0030) begin
         miscompares++;
         $display("FAIL led_prog_leds: got %h want %h", leds, 16'h0030);
      end
      vectors++;
      if (peek(321) !== 32'h30) begin
         miscompares++;
         $display("FAIL led_prog_mem321: got %h want %h", peek(321), 32'h30);
      end
   endtask

   // Continues from the finished LED program: reset mid-run, then rerun.
   task automatic test_reset_mid_program();
      logic ok;
      @(posedge clk);
      #3;
      arst_n = 1'b0;
      #1;
      vectors++;
      if (leds !== 16'h0) begin
         miscompares++;
         $display("FAIL mid_reset_leds: got %h want %h", leds, 16'h0);
      end
      vectors++;
      if (peek(321) !== 32'h30 || peek(320) !== 32'h1) begin
         miscompares++;
         $display("FAIL mid_reset_mem_kept: got %h/%h want %h/%h", peek(321), peek(320), 32'h30, 32'h1);
      end
      vectors++;
      if (peek(0) !== i_op(6'h08, 5'd0, 5'd1, 16'h0018)) begin
         miscompares++;
         $display("FAIL mid_reset_prog_kept: got %h want %h", peek(0), i_op(6'h08, 5'd0, 5'd1, 16'h0018));
      end
      poke(320, 32'h0);
      poke(321, 32'h0);
      release_reset();
      wait_done(ok);
      vectors++;
      if (ok !== 1'b1 || leds !== 16'h0030) begin
         miscompares++;
         $display("FAIL rerun_after_reset: got done=%b leds=%h want done=1 leds=%h", ok, leds, 16'h0030);
      end
   endtask

   task automatic test_store_in_reset();
      enter_reset_clear();
      poke(0, i_op(6'h2B, 5'd0, 5'd0, 16'h0504));
      poke(321, 32'h0000_1234);
      repeat (5) @(negedge clk);
      vectors++;
      if (leds !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_store_leds: got %h want %h", leds, 16'h0);
      end
      vectors++;
      if (peek(321) !== 32'h0000_1234) begin
         miscompares++;
         $display("FAIL reset_store_mem: got %h want %h", peek(321), 32'h0000_1234);
      end
   endtask

   task automatic test_lui_ori();
      logic ok;
      enter_reset_clear();
      poke(0, i_op(6'h0F, 5'd0, 5'd1, 16'hDEAD));
      poke(1, i_op(6'h0D, 5'd1, 5'd1, 16'hBEEF));
      poke(2, i_op(6'h2B, 5'd0, 5'd1, 16'h0504));
      poke_epilogue(3);
      release_reset();
      wait_done(ok);
      vectors++;
      if (ok !== 1'b1 || leds !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL lui_ori_leds: got done=%b leds=%h want done=1 leds=%h", ok, leds, 16'hBEEF);
      end
      vectors++;
      if (peek(321) !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL lui_ori_mem: got %h want %h", peek(321), 32'hDEAD_BEEF);
      end
   endtask

   task automatic test_loop_jal();
      logic        ok;
      logic [31:0] exp [0:2];
      enter_reset_clear();
      poke(0,  i_op(6'h08, 5'd0, 5'd1, 16'h0005));
      poke(1,  i_op(6'h08, 5'd0, 5'd2, 16'h0000));
      poke(2,  r_op(5'd2, 5'd1, 5'd2, 5'd0, 6'h20));
      poke(3,  i_op(6'h08, 5'd1, 5'd1, 16'hFFFF));
      poke(4,  i_op(6'h05, 5'd1, 5'd0, 16'hFFFD));
      poke(5,  j_op(6'h03, 26'd12));
      poke(6,  i_op(6'h2B, 5'd0, 5'd2, 16'h0400));
      poke(7,  i_op(6'h2B, 5'd0, 5'd31, 16'h0404));
      poke(8,  i_op(6'h2B, 5'd0, 5'd5, 16'h0408));
      poke_epilogue(9);
      poke(12, i_op(6'h04, 5'd0, 5'd0, 16'h0001));
      poke(13, i_op(6'h08, 5'd0, 5'd5, 16'h0011));
      poke(14, i_op(6'h08, 5'd5, 5'd5, 16'h0077));
      poke(15, r_op(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
      release_reset();
      wait_done(ok);
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++;
         $display("FAIL loop_done: got %b want %b", ok, 1'b1);
      end
      exp[0] = 32'd15;
      exp[1] = 32'd24;
      exp[2] = 32'h77;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (peek(256 + i) !== exp[i]) begin
            miscompares++;
            $display("FAIL loop_jal_word%0d: got %h want %h", 256 + i, peek(256 + i), exp[i]);
         end
      end
   endtask

   task automatic test_alu_corners();
      logic        ok;
      logic [31:0] exp [0:8];
      enter_reset_clear();
      poke(0,  i_op(6'h08, 5'd0, 5'd0, 16'h0005));
      poke(1,  i_op(6'h2B, 5'd0, 5'd0, 16'h0400));
      poke(2,  i_op(6'h08, 5'd0, 5'd1, 16'hFFFF));
      poke(3,  i_op(6'h08, 5'd0, 5'd2, 16'h0001));
      poke(4,  r_op(5'd1, 5'd2, 5'd4, 5'd0, 6'h2A));
      poke(5,  i_op(6'h2B, 5'd0, 5'd4, 16'h0404));
      poke(6,  i_op(6'h0F, 5'd0, 5'd5, 16'h7FFF));
      poke(7,  i_op(6'h0D, 5'd5, 5'd5, 16'hFFFF));
      poke(8,  i_op(6'h08, 5'd5, 5'd6, 16'h0001));
      poke(9,  i_op(6'h2B, 5'd0, 5'd6, 16'h0408));
      poke(10, i_op(6'h0A, 5'd1, 5'd7, 16'h0000));
      poke(11, i_op(6'h2B, 5'd0, 5'd7, 16'h040C));
      poke(12, i_op(6'h0C, 5'd1, 5'd8, 16'hFFFF));
      poke(13, i_op(6'h2B, 5'd0, 5'd8, 16'h0410));
      poke(14, i_op(6'h23, 5'd0, 5'd9, 16'h0408));
      poke(15, r_op(5'd0, 5'd9, 5'd10, 5'd4, 6'h02));
      poke(16, i_op(6'h2B, 5'd0, 5'd10, 16'h0414));
      poke(17, r_op(5'd2, 5'd1, 5'd11, 5'd0, 6'h22));
      poke(18, i_op(6'h2B, 5'd0, 5'd11, 16'h0418));
      poke(19, r_op(5'd0, 5'd0, 5'd12, 5'd0, 6'h27));
      poke(20, i_op(6'h2B, 5'd0, 5'd12, 16'h041C));
      poke(21, i_op(6'h0E, 5'd8, 5'd13, 16'h00FF));
      poke(22, i_op(6'h2B, 5'd0, 5'd13, 16'h0420));
      poke_epilogue(23);
      release_reset();
      wait_done(ok);
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++;
         $display("FAIL alu_done: got %b want %b", ok, 1'b1);
      end
      exp[0] = 32'h0000_0000;
      exp[1] = 32'h0000_0001;
      exp[2] = 32'h8000_0000;
      exp[3] = 32'h0000_0001;
      exp[4] = 32'h0000_FFFF;
      exp[5] = 32'h0800_0000;
      exp[6] = 32'h0000_0002;
      exp[7] = 32'hFFFF_FFFF;
      exp[8] = 32'h0000_FF00;
      for (int i = 0; i < 9; i++) begin
         vectors++;
         if (peek(256 + i) !== exp[i]) begin
            miscompares++;
            $display("FAIL alu_word%0d: got %h want %h", 256 + i, peek(256 + i), exp[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_led_program();
      test_reset_mid_program();
      test_store_in_reset();
      test_lui_ori();
      test_loop_jal();
      test_alu_corners();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
